// File: rtl/regfile_access_controller_pkg.sv
// Shared constants, command opcodes and FSM encoding for the register file
// access controller.
package regfile_access_controller_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 3;
  localparam int NUM_REGS   = 8;

  // DUMP stops after the beat whose port-A address is the last even register,
  // so the pointer pair never wraps.
  localparam logic [ADDR_WIDTH-1:0] LAST_PAIR_ADDR = ADDR_WIDTH'(NUM_REGS - 2);
  localparam logic [ADDR_WIDTH-1:0] PAIR_STEP      = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] DUMP_FIRST_B   = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_DUMP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    READ  = 2'b10,
    RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/regfile_access_controller.sv
// Initiator-side master for the 8x16 register file: accepts WRITE / READ /
// DUMP commands, drives the file's write and read ports, and returns the read
// data as registered response beats with valid/ready flow control.
module regfile_access_controller
  import regfile_access_controller_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_b,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [DATA_WIDTH-1:0] rsp_data_b,
  output logic                  rsp_last,
  output logic [ADDR_WIDTH-1:0] rf_readA_address,
  output logic [ADDR_WIDTH-1:0] rf_readB_address,
  output logic                  rf_write,
  output logic [DATA_WIDTH-1:0] rf_write_value,
  output logic [ADDR_WIDTH-1:0] rf_write_address,
  input  logic [DATA_WIDTH-1:0] rf_reg_A,
  input  logic [DATA_WIDTH-1:0] rf_reg_B
);

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [ADDR_WIDTH-1:0] ptrA_q, ptrA_d;
  logic [ADDR_WIDTH-1:0] ptrB_q, ptrB_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_last_q, rsp_last_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [DATA_WIDTH-1:0] rsp_data_b_q, rsp_data_b_d;

  // State, latched command and response holding register; reset aborts any
  // operation in flight but never touches the register file contents.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      op_q         <= OP_NOP;
      ptrA_q       <= '0;
      ptrB_q       <= '0;
      data_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_last_q   <= 1'b0;
      rsp_addr_q   <= '0;
      rsp_data_q   <= '0;
      rsp_data_b_q <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      ptrA_q       <= ptrA_d;
      ptrB_q       <= ptrB_d;
      data_q       <= data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_last_q   <= rsp_last_d;
      rsp_addr_q   <= rsp_addr_d;
      rsp_data_q   <= rsp_data_d;
      rsp_data_b_q <= rsp_data_b_d;
    end
  end

  // Next-state logic and register-file port drive; a WRITE always falls into
  // READ so the written value comes back as the acknowledge beat.
  always_comb begin
    state_d          = state_q;
    op_d             = op_q;
    ptrA_d           = ptrA_q;
    ptrB_d           = ptrB_q;
    data_d           = data_q;
    rsp_valid_d      = rsp_valid_q;
    rsp_last_d       = rsp_last_q;
    rsp_addr_d       = rsp_addr_q;
    rsp_data_d       = rsp_data_q;
    rsp_data_b_d     = rsp_data_b_q;
    cmd_ready        = 1'b0;
    rf_write         = 1'b0;
    rf_write_address = '0;
    rf_write_value   = '0;
    rf_readA_address = '0;
    rf_readB_address = '0;

    case (state_q)
      IDLE: begin
        cmd_ready = RST_N;
        if (cmd_valid && cmd_ready) begin
          op_d   = op_e'(cmd_op);
          data_d = cmd_data;
          case (op_e'(cmd_op))
            OP_WRITE: begin
              ptrA_d  = cmd_addr;
              ptrB_d  = cmd_addr;
              state_d = WRITE;
            end
            OP_READ: begin
              ptrA_d  = cmd_addr;
              ptrB_d  = cmd_addr_b;
              state_d = READ;
            end
            OP_DUMP: begin
              ptrA_d  = '0;
              ptrB_d  = DUMP_FIRST_B;
              state_d = READ;
            end
            default: state_d = IDLE;
          endcase
        end
      end

      WRITE: begin
        rf_write         = 1'b1;
        rf_write_address = ptrA_q;
        rf_write_value   = data_q;
        state_d          = READ;
      end

      READ: begin
        rf_readA_address = ptrA_q;
        rf_readB_address = ptrB_q;
        rsp_data_d       = rf_reg_A;
        rsp_data_b_d     = rf_reg_B;
        rsp_addr_d       = ptrA_q;
        rsp_valid_d      = 1'b1;
        rsp_last_d       = (op_q != OP_DUMP) || (ptrA_q == LAST_PAIR_ADDR);
        state_d          = RESP;
      end

      RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (op_q == OP_DUMP && !rsp_last_q) begin
            ptrA_d  = ptrA_q + PAIR_STEP;
            ptrB_d  = ptrB_q + PAIR_STEP;
            state_d = READ;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_last   = rsp_last_q;
  assign rsp_addr   = rsp_addr_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_data_b = rsp_data_b_q;

endmodule

// File: tb/tb_regfile_access_controller.sv
// Directed bench for regfile_access_controller wired to a behavioural 8x16
// register file (synchronous write, combinational dual read).
module tb_regfile_access_controller;
  import regfile_access_controller_pkg::*;

  logic                  clock;
  logic                  rstN;
  logic                  cmdValid;
  logic                  cmdReady;
  logic [1:0]            cmdOp;
  logic [ADDR_WIDTH-1:0] cmdAddr;
  logic [ADDR_WIDTH-1:0] cmdAddrB;
  logic [DATA_WIDTH-1:0] cmdData;
  logic                  rspValid;
  logic                  rspReady;
  logic [ADDR_WIDTH-1:0] rspAddr;
  logic [DATA_WIDTH-1:0] rspData;
  logic [DATA_WIDTH-1:0] rspDataB;
  logic                  rspLast;
  logic [ADDR_WIDTH-1:0] rfReadAAddress;
  logic [ADDR_WIDTH-1:0] rfReadBAddress;
  logic                  rfWrite;
  logic [DATA_WIDTH-1:0] rfWriteValue;
  logic [ADDR_WIDTH-1:0] rfWriteAddress;
  logic [DATA_WIDTH-1:0] rfRegA;
  logic [DATA_WIDTH-1:0] rfRegB;

  logic [DATA_WIDTH-1:0] rfRegs [NUM_REGS];

  int checkCount = 0;
  int errorCount = 0;

  regfile_access_controller dut (
    .CLK              (clock),
    .RST_N            (rstN),
    .cmd_valid        (cmdValid),
    .cmd_ready        (cmdReady),
    .cmd_op           (cmdOp),
    .cmd_addr         (cmdAddr),
    .cmd_addr_b       (cmdAddrB),
    .cmd_data         (cmdData),
    .rsp_valid        (rspValid),
    .rsp_ready        (rspReady),
    .rsp_addr         (rspAddr),
    .rsp_data         (rspData),
    .rsp_data_b       (rspDataB),
    .rsp_last         (rspLast),
    .rf_readA_address (rfReadAAddress),
    .rf_readB_address (rfReadBAddress),
    .rf_write         (rfWrite),
    .rf_write_value   (rfWriteValue),
    .rf_write_address (rfWriteAddress),
    .rf_reg_A         (rfRegA),
    .rf_reg_B         (rfRegB)
  );

  // Behavioural register file: commits on the rising edge, reads combinationally.
  always @(posedge clock) begin
    if (rfWrite) rfRegs[rfWriteAddress] <= rfWriteValue;
  end
  assign rfRegA = rfRegs[rfReadAAddress];
  assign rfRegB = rfRegs[rfReadBAddress];

  // Free-running clock, 10 time-unit period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Presents a command at a negedge and returns at the negedge after it is accepted.
  task automatic applyStimulus(input logic [1:0] op, input logic [ADDR_WIDTH-1:0] a,
                               input logic [ADDR_WIDTH-1:0] b,
                               input logic [DATA_WIDTH-1:0] d);
    int waited = 0;
    cmdValid = 1'b1;
    cmdOp    = op;
    cmdAddr  = a;
    cmdAddrB = b;
    cmdData  = d;
    while (cmdReady !== 1'b1 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (cmdReady !== 1'b1) begin
      checkOutput("cmd_accept_timeout", 32'd0, 32'd1);
      cmdValid = 1'b0;
    end else begin
      @(posedge clock);
      @(negedge clock);
      cmdValid = 1'b0;
      cmdOp    = OP_NOP;
    end
  endtask

  task automatic waitRsp(input int maxCycles);
    int n = 0;
    while (rspValid !== 1'b1 && n < maxCycles) begin
      @(negedge clock);
      n++;
    end
    if (rspValid !== 1'b1) checkOutput("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic doWrite(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
    applyStimulus(OP_WRITE, a, '0, d);
    waitRsp(6);
    checkOutput("wr_ack_data", 32'(rspData), 32'(d));
    @(negedge clock);
  endtask

  // Full DUMP with an optional 3-cycle stall on one beat; expects Rn = 0x1000+n.
  task automatic runDump(input int stallBeat);
    applyStimulus(OP_DUMP, '0, '0, '0);
    for (int beat = 0; beat < NUM_REGS / 2; beat++) begin
      if (beat == stallBeat) rspReady = 1'b0;
      waitRsp(8);
      checkOutput("dump_addr", 32'(rspAddr), 32'(2 * beat));
      checkOutput("dump_data", 32'(rspData), 32'h1000 + 32'(2 * beat));
      checkOutput("dump_data_b", 32'(rspDataB), 32'h1000 + 32'(2 * beat + 1));
      checkOutput("dump_last", 32'(rspLast), (beat == NUM_REGS / 2 - 1) ? 32'd1 : 32'd0);
      checkOutput("dump_cmd_ready", 32'(cmdReady), 32'd0);
      if (beat == stallBeat) begin
        for (int s = 0; s < 3; s++) begin
          @(negedge clock);
          checkOutput("stall_valid", 32'(rspValid), 32'd1);
          checkOutput("stall_addr", 32'(rspAddr), 32'(2 * beat));
          checkOutput("stall_data", 32'(rspData), 32'h1000 + 32'(2 * beat));
          checkOutput("stall_data_b", 32'(rspDataB), 32'h1000 + 32'(2 * beat + 1));
        end
        rspReady = 1'b1;
      end
      @(negedge clock);
      checkOutput("dump_no_dup", 32'(rspValid), 32'd0);
    end
    checkOutput("dump_done_ready", 32'(cmdReady), 32'd1);
  endtask

  // Main directed sequence.
  initial begin
    rstN     = 1'b0;
    cmdValid = 1'b0;
    cmdOp    = OP_NOP;
    cmdAddr  = '0;
    cmdAddrB = '0;
    cmdData  = '0;
    rspReady = 1'b1;

    // Reset values.
    @(negedge clock);
    @(negedge clock);
    checkOutput("rst_cmd_ready", 32'(cmdReady), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("rst_rsp_last", 32'(rspLast), 32'd0);
    checkOutput("rst_rsp_data", 32'(rspData), 32'd0);
    checkOutput("rst_rf_write", 32'(rfWrite), 32'd0);
    checkOutput("rst_rf_wvalue", 32'(rfWriteValue), 32'd0);
    checkOutput("rst_rf_raddr", 32'(rfReadAAddress), 32'd0);
    rstN = 1'b1;
    @(negedge clock);
    checkOutput("post_rst_ready", 32'(cmdReady), 32'd1);

    // WRITE addr=1 data=1234: one-cycle strobe, readback two cycles after accept.
    applyStimulus(OP_WRITE, 3'd1, 3'd0, 16'h1234);
    checkOutput("wr_strobe", 32'(rfWrite), 32'd1);
    checkOutput("wr_addr", 32'(rfWriteAddress), 32'd1);
    checkOutput("wr_value", 32'(rfWriteValue), 32'h1234);
    checkOutput("wr_busy", 32'(cmdReady), 32'd0);
    checkOutput("wr_rsp_early0", 32'(rspValid), 32'd0);
    @(negedge clock);
    checkOutput("wr_strobe_drop", 32'(rfWrite), 32'd0);
    checkOutput("wr_rsp_early1", 32'(rspValid), 32'd0);
    checkOutput("wr_committed", 32'(rfRegs[1]), 32'h1234);
    @(negedge clock);
    checkOutput("wr_rsp_valid", 32'(rspValid), 32'd1);
    checkOutput("wr_rsp_addr", 32'(rspAddr), 32'd1);
    checkOutput("wr_rsp_data", 32'(rspData), 32'h1234);
    checkOutput("wr_rsp_last", 32'(rspLast), 32'd1);
    @(negedge clock);
    checkOutput("wr_rsp_retired", 32'(rspValid), 32'd0);
    checkOutput("wr_back_idle", 32'(cmdReady), 32'd1);

    // WRITE addr=2, then READ pair (1,2) one cycle after accept.
    doWrite(3'd2, 16'hABCD);
    applyStimulus(OP_READ, 3'd1, 3'd2, 16'h0);
    checkOutput("rd_rsp_early", 32'(rspValid), 32'd0);
    @(negedge clock);
    checkOutput("rd_rsp_valid", 32'(rspValid), 32'd1);
    checkOutput("rd_rsp_addr", 32'(rspAddr), 32'd1);
    checkOutput("rd_data_a", 32'(rspData), 32'h1234);
    checkOutput("rd_data_b", 32'(rspDataB), 32'hABCD);
    checkOutput("rd_last", 32'(rspLast), 32'd1);
    @(negedge clock);

    // Reset during WRITE: strobe drops at once and nothing commits.
    applyStimulus(OP_WRITE, 3'd1, 3'd0, 16'h5555);
    checkOutput("rw_strobe", 32'(rfWrite), 32'd1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("rw_strobe_drop", 32'(rfWrite), 32'd0);
    checkOutput("rw_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("rw_cmd_ready", 32'(cmdReady), 32'd0);
    @(negedge clock);
    checkOutput("rw_no_commit", 32'(rfRegs[1]), 32'h1234);
    rstN = 1'b1;
    @(negedge clock);
    checkOutput("rw_ready_again", 32'(cmdReady), 32'd1);

    // Fill Rn = 0x1000+n, then a free-flowing DUMP and a backpressured DUMP.
    for (int n = 0; n < NUM_REGS; n++) doWrite(ADDR_WIDTH'(n), 16'h1000 + 16'(n));
    runDump(-1);
    runDump(1);

    // NOP is consumed silently; READ 7/7 returns R7 on both fields.
    applyStimulus(OP_NOP, 3'd5, 3'd6, 16'hFFFF);
    checkOutput("nop_rsp", 32'(rspValid), 32'd0);
    checkOutput("nop_write", 32'(rfWrite), 32'd0);
    checkOutput("nop_ready", 32'(cmdReady), 32'd1);
    @(negedge clock);
    checkOutput("nop_rsp_later", 32'(rspValid), 32'd0);
    applyStimulus(OP_READ, 3'd7, 3'd7, 16'h0);
    @(negedge clock);
    checkOutput("same_valid", 32'(rspValid), 32'd1);
    checkOutput("same_addr", 32'(rspAddr), 32'd7);
    checkOutput("same_data_a", 32'(rspData), 32'h1007);
    checkOutput("same_data_b", 32'(rspDataB), 32'h1007);
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/regfile_access_controller.md
Name: regfile_access_controller

Overview:
- Initiator-side master for the 8x16 ProgrammableRegisterFile; it drives the register file's write port and both read ports.
- Accepts host/debug commands (WRITE, READ pair, DUMP all) over a valid/ready command channel.
- Returns register contents over a valid/ready response channel.
- Used for debug load/inspect and for bring-up of the multi-cycle processor datapath.

Parameters:
DATA_WIDTH, 16, register width
ADDR_WIDTH, 3, register address width
NUM_REGS, 8, register count; must equal 2**ADDR_WIDTH and be even

Ports:
CLK  in  1  clock, rising-edge
RST_N  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_op  in  2  00 NOP, 01 WRITE, 10 READ, 11 DUMP
cmd_addr  in  ADDR_WIDTH  write address / read-A address
cmd_addr_b  in  ADDR_WIDTH  read-B address (READ only)
cmd_data  in  DATA_WIDTH  write value (WRITE only)
rsp_valid  out  1  response beat present
rsp_ready  in  1  consumer accepts beat
rsp_addr  out  ADDR_WIDTH  address read on port A for this beat
rsp_data  out  DATA_WIDTH  port-A value
rsp_data_b  out  DATA_WIDTH  port-B value
rsp_last  out  1  final beat of the command
rf_readA_address  out  ADDR_WIDTH  to input_reg_readA_address
rf_readB_address  out  ADDR_WIDTH  to input_reg_readB_address
rf_write  out  1  to input_reg_write
rf_write_value  out  DATA_WIDTH  to input_reg_write_value
rf_write_address  out  ADDR_WIDTH  to input_reg_write_address
rf_reg_A  in  DATA_WIDTH  from output_reg_A (combinational read)
rf_reg_B  in  DATA_WIDTH  from output_reg_B

Behaviour:
- Register file contract: write commits on rising CLK when rf_write=1; reads are combinational from the addresses.
- Reset (RST_N=0, asynchronous):
  - state=IDLE; cmd_ready=0 while in reset, then 1 once in IDLE.
  - rsp_valid=0, rsp_last=0, rsp_addr/rsp_data/rsp_data_b=0.
  - rf_write=0; all rf addresses and rf_write_value=0.
- Reset mid-operation: aborts immediately. A WRITE whose rf_write is dropped by reset before the edge does not commit. The controller never resets register contents.
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE:
  - cmd_ready=1; rf_write=0; rf read addresses=0.
  - On cmd_valid&&cmd_ready, latch op/addr/addr_b/data.
  - WRITE goes to WRITE. READ goes to READ with ptrA=cmd_addr, ptrB=cmd_addr_b. DUMP goes to READ with ptrA=0, ptrB=1.
  - NOP is consumed: stay IDLE, no rf activity, no response.
- WRITE (1 cycle):
  - rf_write=1, rf_write_address=addr, rf_write_value=data; value commits at the exiting edge.
  - Next state READ with ptrA=ptrB=addr, giving a readback acknowledge.
- READ (1 cycle):
  - rf_readA_address=ptrA, rf_readB_address=ptrB.
  - At the exiting edge, register rsp_data<=rf_reg_A, rsp_data_b<=rf_reg_B, rsp_addr<=ptrA, rsp_valid<=1.
  - rsp_last<=1 unless op=DUMP and ptrA!=NUM_REGS-2.
- RESP:
  - Hold all rsp_* stable while rsp_valid && !rsp_ready.
  - On handshake, rsp_valid<=0. If DUMP and not last: ptrA+=2, ptrB+=2, go to READ. Otherwise go to IDLE.
- cmd_ready=0 in every state except IDLE; there are no back-to-back commands within a cycle of response retirement.
- Latency from accept edge E0:
  - READ: rsp_valid high after E1.
  - WRITE: commit at E1, rsp_valid after E2.
  - DUMP: NUM_REGS/2 beats of pairs (0,1),(2,3),...,(6,7), with a minimum of 2 cycles per beat when rsp_ready is held high.
- Same-address READ (cmd_addr==cmd_addr_b) is legal; both data fields are equal.
- Pointer arithmetic is ADDR_WIDTH-bit. DUMP terminates on ptrA==NUM_REGS-2, so no wrap occurs.
- rf_write is high only in WRITE and is never high for more than one cycle per command.

Decomposition:
- Shared package: DATA_WIDTH, ADDR_WIDTH, NUM_REGS; op encodings OP_NOP/OP_WRITE/OP_READ/OP_DUMP; FSM state encoding.
- A single module with no sub-module. The response holding register is small enough to stay inline.
- Bench instantiates this block directly wired to ProgrammableRegisterFile.

Test Plan:
- Reset: RST_N=0 mid-WRITE (rf_write=1) before the edge -> rf_write drops immediately, target register unchanged, rsp_valid=0. After release, cmd_ready=1 within 1 cycle.
- WRITE addr=1 data=16'h1234, rsp_ready=1 -> rf_write high exactly 1 cycle; rsp_valid 2 cycles after accept with rsp_addr=1, rsp_data=16'h1234, rsp_last=1.
- WRITE addr=2 16'hABCD, then READ addr=1 addr_b=2 -> rsp_data=16'h1234, rsp_data_b=16'hABCD, rsp_last=1, 1 cycle after accept.
- DUMP after writing Rn=16'h1000+n, rsp_ready=1 -> 4 beats: rsp_addr 0,2,4,6; data/data_b pairs (1000,1001)...(1006,1007); rsp_last only on beat 4; cmd_ready=0 throughout.
- Backpressure: DUMP with rsp_ready low 3 cycles on beat 2 -> rsp_addr=2 and data held stable, no skipped or duplicated beats.
- NOP, then cmd_valid held with op=READ addr=7 addr_b=7 -> NOP produces no rsp_valid and no rf_write; READ returns R7 on both fields.
